iob_tb_rr_arbiter: RTL

IOB_TB_RR_ARBITER -- requirements
Module: iob_tb_rr_arbiter

---
 rtl/iob_tb_rr_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/iob_tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// iob_tb_rr_arbiter
//
// Purpose: round-robin arbiter that lets N_MASTERS IOb-native testbench
// masters share one IOb-native slave. Only one transaction is in flight at a
// time. A write finishes at the request handshake. A read waits for the
// slave's rvalid, which goes back to the granted master only.
//
// Ports:
//   clk_i, arst_i, cke_i      clock, async active-high reset, clock enable
//   m_valid_i/m_addr_i/...    packed per-master request buses (master i at
//                             slice i)
//   m_rdata_o                 shared read data; zero unless m_rvalid_o is set
//   m_ready_o, m_rvalid_o     per-master handshake strobes (one-hot or zero)
//   s_*                       single slave-side IOb-native port
//   err_o                     sticky watchdog timeout flag
//
// Optional feature: define IOB_TB_ARB_TIMEOUT_EN to add a TIMEOUT_W-bit
// watchdog. It aborts a GRANT or WAIT_R that stalls. A stalled read is
// completed with a 0xDEADBEEF pattern. Without the macro, err_o is always 0.
// -----------------------------------------------------------------------------
module iob_tb_rr_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT_W = 16
) (
   input  logic                          clk_i,
   input  logic                          arst_i,
   input  logic                          cke_i,
   input  logic [N_MASTERS-1:0]          m_valid_i,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
   input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
   output logic [DATA_W-1:0]             m_rdata_o,
   output logic [N_MASTERS-1:0]          m_ready_o,
   output logic [N_MASTERS-1:0]          m_rvalid_o,
   output logic                          s_valid_o,
   output logic [ADDR_W-1:0]             s_addr_o,
   output logic [DATA_W-1:0]             s_wdata_o,
   output logic [DATA_W/8-1:0]           s_wstrb_o,
   input  logic [DATA_W-1:0]             s_rdata_i,
   input  logic                          s_ready_i,
   input  logic                          s_rvalid_i,
   output logic                          err_o
);

   localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int SW = DATA_W / 8;

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, WAIT_R = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [GW-1:0]     g_q, g_d;
   logic [GW-1:0]     ptr_q, ptr_d;

   logic [GW-1:0]     sel;
   logic              found;
   int                idx;
   logic              g_valid;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_wdata;
   logic [SW-1:0]     g_wstrb;
   logic              timeout;
   logic              to_fire;   // watchdog aborts the current transaction
   logic              to_rd;     // ... and that transaction was a read
   logic              rd_pulse;  // read response goes to the master this cycle

   // Request of the granted master
   always_comb begin
      g_valid = m_valid_i[g_q];
      g_addr  = m_addr_i[int'(g_q)*ADDR_W +: ADDR_W];
      g_wdata = m_wdata_i[int'(g_q)*DATA_W +: DATA_W];
      g_wstrb = m_wstrb_i[int'(g_q)*SW +: SW];
   end

   // Round-robin search: first requester at or after ptr, wrapping around
   always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N_MASTERS; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= N_MASTERS) idx = idx - N_MASTERS;
         if (!found && m_valid_i[idx]) begin
            found = 1'b1;
            sel   = GW'(idx);
         end
      end
   end

   // Next-state logic; nothing moves while cke_i is low
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      ptr_d   = ptr_q;
      to_fire = 1'b0;
      to_rd   = 1'b0;
      if (cke_i) begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  g_d     = sel;
                  state_d = GRANT;
               end
            end
            GRANT: begin
               if (!g_valid) begin
                  // Master withdrew its request: abort, pointer untouched
                  state_d = IDLE;
               end else if (s_ready_i) begin
                  ptr_d   = (g_q == GW'(N_MASTERS - 1)) ? '0 : g_q + 1'b1;
                  state_d = (|g_wstrb) ? IDLE : WAIT_R;
               end else if (timeout) begin
                  state_d = IDLE;
                  to_fire = 1'b1;
               end
            end
            WAIT_R: begin
               if (s_rvalid_i) begin
                  state_d = IDLE;
               end else if (timeout) begin
                  state_d = IDLE;
                  to_fire = 1'b1;
                  to_rd   = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q <= IDLE;
         g_q     <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
      end
   end

   // Slave side forwards the granted request combinationally. s_valid_o is
   // held low while cke_i is low, so the slave cannot complete a handshake
   // that the frozen arbiter would miss.
   assign s_valid_o = (state_q == GRANT) & g_valid & cke_i;
   assign s_addr_o  = (state_q == GRANT) ? g_addr  : '0;
   assign s_wdata_o = (state_q == GRANT) ? g_wdata : '0;
   assign s_wstrb_o = (state_q == GRANT) ? g_wstrb : '0;

   assign rd_pulse = (state_q == WAIT_R) & cke_i & (s_rvalid_i | to_rd);

   for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
      assign m_ready_o[gi]  = (state_q == GRANT) & cke_i & (g_q == GW'(gi)) & s_ready_i;
      assign m_rvalid_o[gi] = rd_pulse & (g_q == GW'(gi));
   end

`ifdef IOB_TB_ARB_TIMEOUT_EN
   localparam logic [DATA_W-1:0] TO_RDATA = DATA_W'({DATA_W/32{32'hDEADBEEF}});

   logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
   logic                 err_q, err_d;

   // Counter restarts on every entry into GRANT or WAIT_R (also GRANT->WAIT_R)
   always_comb begin
      wdog_d = wdog_q;
      err_d  = err_q | to_fire;
      if (cke_i) begin
         if (state_d != state_q && state_d != IDLE) wdog_d = '0;
         else if (state_q != IDLE)                  wdog_d = wdog_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end

   assign timeout   = (state_q != IDLE) & (&wdog_q);
   assign err_o     = err_q;
   // Real slave data wins if it shows up in the same cycle as the timeout
   assign m_rdata_o = !rd_pulse ? '0 : (s_rvalid_i ? s_rdata_i : TO_RDATA);
`else
   // No watchdog: nothing can time out, so to_fire never asserts and err_o is 0.
   assign timeout   = 1'b0;
   assign err_o     = to_fire & (TIMEOUT_W > 0);
   assign m_rdata_o = rd_pulse ? s_rdata_i : '0;
`endif

endmodule
